fetcher: RTL and testbench

- Instruction-fetch stage of the IF unit.
- Holds the architectural fetch PC and issues one request at a time to the instruction cache.
- On each returned word, consults the branch predictor combinationally to choose the next PC, then pushes {instr, pc, predicted_taken} into an internal instruction queue that the decoder drains.
- On ROB mispredict/flush, redirects the PC, clears the queue and drops any in-flight cache response.

---
 rtl/fetcher_pkg.sv | 21 ++
 rtl/fetcher_queue.sv | 67 ++++++
 rtl/fetcher.sv | 127 ++++++++++++
 tb/tb_fetcher.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetcher_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   fetch_state_t : fetch FSM encoding (IDLE / WAIT / DROP)
//   iq_entry_t    : instruction-queue entry, bit 64 = predicted taken,
//                   63:32 = fetch PC, 31:0 = instruction word
package fetcher_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic            pred;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } iq_entry_t;

endpackage

// File: rtl/fetcher_queue.sv
// Circular instruction queue between the fetcher and the decoder.
//   clk, rst       : clock, synchronous active-high reset
//   en             : global enable, low freezes pointers and contents
//   push/push_entry: write one entry at tail
//   pop            : advance head (ignored when empty)
//   clear          : empty the queue, overrides push and pop
//   head_entry     : entry at head
//   full, empty    : occupancy flags
module fetcher_queue
  import fetcher_pkg::*;
#(
  parameter int IQ_DEPTH = 16,
  parameter int IQ_IDX_W = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      en,
  input  logic      push,
  input  iq_entry_t push_entry,
  input  logic      pop,
  input  logic      clear,
  output iq_entry_t head_entry,
  output logic      full,
  output logic      empty
);

  localparam logic [IQ_IDX_W:0] FULL_COUNT = (IQ_IDX_W + 1)'(IQ_DEPTH);

  iq_entry_t           mem [IQ_DEPTH];
  logic [IQ_IDX_W-1:0] head;
  logic [IQ_IDX_W-1:0] tail;
  logic [IQ_IDX_W:0]   count;
  logic                do_push;
  logic                do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full & ~clear;
  assign do_pop  = pop & ~empty & ~clear;

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (en) begin
      if (clear) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (do_push) tail <= tail + 1'b1;
        if (do_pop)  head <= head + 1'b1;
        if (do_push && !do_pop)      count <= count + 1'b1;
        else if (do_pop && !do_push) count <= count - 1'b1;
      end
    end
  end

  // Storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (!rst && en && do_push) mem[tail] <= push_entry;
  end

  assign head_entry = mem[head];

endmodule

// File: rtl/fetcher.sv
// Instruction-fetch stage: holds the fetch PC, issues one ICache request
// at a time, queries the branch predictor on each returned word and queues
// {instr, pc, predicted_taken} for the decoder.
//   ic_req_*   : request pulse and address to the ICache
//   ic_resp_*  : returned instruction word (one-cycle pulse)
//   pred_*     : combinational branch-predictor handshake
//   iq_out_*   : head of the instruction queue, popped on valid & ready
//   rob_flush* : redirect; clears the queue and drops any in-flight word
//
// state      | meaning
// FETCH_IDLE | no request outstanding, issue when the queue has room
// FETCH_WAIT | request outstanding, response will be queued
// FETCH_DROP | request outstanding but flushed, response will be discarded
module fetcher
  import fetcher_pkg::*;
#(
  parameter int          IQ_DEPTH = 16,
  parameter int          IQ_IDX_W = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  output logic        ic_req_valid,
  output logic [31:0] ic_req_pc,
  input  logic        ic_resp_valid,
  input  logic [31:0] ic_resp_instr,
  output logic        pred_instr_valid,
  output logic [31:0] pred_instr,
  output logic [31:0] pred_cur_pc,
  input  logic        pred_if_jump,
  input  logic [31:0] pred_predict_pc,
  output logic        iq_out_valid,
  output logic [31:0] iq_out_instr,
  output logic [31:0] iq_out_pc,
  output logic        iq_out_pred_jump,
  input  logic        iq_out_ready,
  input  logic        rob_flush,
  input  logic [31:0] rob_flush_pc
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         issue;
  logic         push;
  logic         iq_full;
  logic         iq_empty;
  iq_entry_t    push_entry;
  iq_entry_t    head_entry;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    issue   = 1'b0;
    push    = 1'b0;
    case (state_q)
      FETCH_IDLE: begin
        if (!rob_flush && !iq_full) begin
          issue   = 1'b1;
          state_d = FETCH_WAIT;
        end
      end
      FETCH_WAIT: begin
        if (rob_flush) begin
          // A response landing in the flush cycle is consumed here, so
          // there is nothing left to drop.
          state_d = ic_resp_valid ? FETCH_IDLE : FETCH_DROP;
        end else if (ic_resp_valid) begin
          push    = 1'b1;
          pc_d    = pred_predict_pc;
          state_d = FETCH_IDLE;
        end
      end
      FETCH_DROP: begin
        // Leaving DROP only on the stale response keeps at most one
        // request outstanding, flush or not.
        if (ic_resp_valid) state_d = FETCH_IDLE;
      end
      default: state_d = FETCH_IDLE;
    endcase
    if (rob_flush) pc_d = rob_flush_pc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH_IDLE;
      pc_q         <= RESET_PC;
      ic_req_valid <= 1'b0;
      ic_req_pc    <= RESET_PC;
    end else if (rdy) begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ic_req_valid <= issue;
      if (issue) ic_req_pc <= pc_q;
    end
  end

  assign push_entry.pred  = pred_if_jump;
  assign push_entry.pc    = pc_q;
  assign push_entry.instr = ic_resp_instr;

  fetcher_queue #(
    .IQ_DEPTH (IQ_DEPTH),
    .IQ_IDX_W (IQ_IDX_W)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .en         (rdy),
    .push       (push),
    .push_entry (push_entry),
    .pop        (iq_out_ready),
    .clear      (rob_flush),
    .head_entry (head_entry),
    .full       (iq_full),
    .empty      (iq_empty)
  );

  assign pred_instr_valid = (state_q == FETCH_WAIT) && ic_resp_valid;
  assign pred_instr       = ic_resp_instr;
  assign pred_cur_pc      = pc_q;

  assign iq_out_valid     = ~iq_empty;
  assign iq_out_instr     = head_entry.instr;
  assign iq_out_pc        = head_entry.pc;
  assign iq_out_pred_jump = head_entry.pred;

endmodule

// File: tb/tb_fetcher.sv
module tb_fetcher;

  localparam logic [31:0] ADDI = 32'h0000_0013;
  localparam logic [31:0] JAL8 = 32'h0080_006F;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        ic_req_valid;
  logic [31:0] ic_req_pc;
  logic        ic_resp_valid;
  logic [31:0] ic_resp_instr;
  logic        pred_instr_valid;
  logic [31:0] pred_instr;
  logic [31:0] pred_cur_pc;
  logic        pred_if_jump;
  logic [31:0] pred_predict_pc;
  logic        iq_out_valid;
  logic [31:0] iq_out_instr;
  logic [31:0] iq_out_pc;
  logic        iq_out_pred_jump;
  logic        iq_out_ready;
  logic        rob_flush;
  logic [31:0] rob_flush_pc;

  int vectors = 0;
  int miscompares = 0;

  fetcher #(.IQ_DEPTH(16), .IQ_IDX_W(4), .RESET_PC(32'h0)) dut (
    .clk              (clk),
    .rst              (rst),
    .rdy              (rdy),
    .ic_req_valid     (ic_req_valid),
    .ic_req_pc        (ic_req_pc),
    .ic_resp_valid    (ic_resp_valid),
    .ic_resp_instr    (ic_resp_instr),
    .pred_instr_valid (pred_instr_valid),
    .pred_instr       (pred_instr),
    .pred_cur_pc      (pred_cur_pc),
    .pred_if_jump     (pred_if_jump),
    .pred_predict_pc  (pred_predict_pc),
    .iq_out_valid     (iq_out_valid),
    .iq_out_instr     (iq_out_instr),
    .iq_out_pc        (iq_out_pc),
    .iq_out_pred_jump (iq_out_pred_jump),
    .iq_out_ready     (iq_out_ready),
    .rob_flush        (rob_flush),
    .rob_flush_pc     (rob_flush_pc)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a request becomes visible: respond two cycles later,
  // return once the follow-up request (if any) is visible.
  task automatic serve(input logic [31:0] instr, input logic jump, input logic [31:0] target);
    cyc();
    ic_resp_valid   = 1'b1;
    ic_resp_instr   = instr;
    pred_if_jump    = jump;
    pred_predict_pc = target;
    cyc();
    ic_resp_valid   = 1'b0;
    pred_if_jump    = 1'b0;
    cyc();
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b0;
    ic_resp_valid = 1'b0; ic_resp_instr = '0;
    pred_if_jump = 1'b0; pred_predict_pc = '0;
    iq_out_ready = 1'b0; rob_flush = 1'b0; rob_flush_pc = '0;

    // reset with rdy low: reset still wins
    cyc(); cyc();
    check("rst_req_valid", ic_req_valid, 1'b0);
    check("rst_req_pc", ic_req_pc, 32'h0);
    check("rst_iq_valid", iq_out_valid, 1'b0);

    rst = 1'b0; rdy = 1'b1;
    cyc();
    check("first_req_valid", ic_req_valid, 1'b1);
    check("first_req_pc", ic_req_pc, 32'h0);

    cyc();
    check("req_pulse_ends", ic_req_valid, 1'b0);
    ic_resp_valid = 1'b1; ic_resp_instr = ADDI; pred_if_jump = 1'b0; pred_predict_pc = 32'h4;
    #1;
    check("pred_valid", pred_instr_valid, 1'b1);
    check("pred_cur_pc", pred_cur_pc, 32'h0);
    check("pred_instr", pred_instr, ADDI);
    cyc();
    ic_resp_valid = 1'b0;
    check("push_iq_valid", iq_out_valid, 1'b1);
    check("push_iq_pc", iq_out_pc, 32'h0);
    check("push_iq_instr", iq_out_instr, ADDI);
    check("push_iq_pred", iq_out_pred_jump, 1'b0);
    check("idle_no_req", ic_req_valid, 1'b0);
    cyc();
    check("req1_valid", ic_req_valid, 1'b1);
    check("req1_pc", ic_req_pc, 32'h4);

    serve(ADDI, 1'b0, 32'h8);
    check("req2_pc", ic_req_pc, 32'h8);
    serve(ADDI, 1'b0, 32'hC);
    check("req3_pc", ic_req_pc, 32'hC);
    serve(ADDI, 1'b0, 32'h10);
    check("req4_pc", ic_req_pc, 32'h10);
    serve(JAL8, 1'b1, 32'h18);
    check("jal_next_req_valid", ic_req_valid, 1'b1);
    check("jal_next_req_pc", ic_req_pc, 32'h18);

    // drain the four addi entries to expose the jal entry
    iq_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    iq_out_ready = 1'b0;
    check("jal_head_pc", iq_out_pc, 32'h10);
    check("jal_head_instr", iq_out_instr, JAL8);
    check("jal_head_pred", iq_out_pred_jump, 1'b1);
    check("wait_no_req", ic_req_valid, 1'b0);

    // fill: jal entry + 15 more = 16
    for (int i = 0; i < 15; i++) begin
      serve(ADDI, 1'b0, 32'h1C + 32'(4 * i));
      check("fill_req_valid", ic_req_valid, (i < 14) ? 1'b1 : 1'b0);
      if (i < 14) check("fill_req_pc", ic_req_pc, 32'h1C + 32'(4 * i));
    end
    cyc(); cyc(); cyc();
    check("full_no_req", ic_req_valid, 1'b0);
    check("full_iq_valid", iq_out_valid, 1'b1);
    check("full_head_pc", iq_out_pc, 32'h10);

    iq_out_ready = 1'b1;
    cyc();
    iq_out_ready = 1'b0;
    check("pop1_no_req_yet", ic_req_valid, 1'b0);
    check("pop1_head_pc", iq_out_pc, 32'h18);
    cyc();
    check("after_pop_req_valid", ic_req_valid, 1'b1);
    check("after_pop_req_pc", ic_req_pc, 32'h54);
    cyc();
    check("after_pop_single_req", ic_req_valid, 1'b0);

    // flush while WAIT, then the stale response must be dropped
    rob_flush = 1'b1; rob_flush_pc = 32'h100;
    cyc();
    rob_flush = 1'b0;
    check("flush_iq_empty", iq_out_valid, 1'b0);
    check("flush_no_req", ic_req_valid, 1'b0);
    ic_resp_valid = 1'b1; ic_resp_instr = ADDI; pred_if_jump = 1'b1; pred_predict_pc = 32'h200;
    #1;
    check("drop_pred_valid", pred_instr_valid, 1'b0);
    cyc();
    ic_resp_valid = 1'b0; pred_if_jump = 1'b0;
    check("drop_no_push", iq_out_valid, 1'b0);
    check("drop_no_req", ic_req_valid, 1'b0);
    cyc();
    check("flush_req_valid", ic_req_valid, 1'b1);
    check("flush_req_pc", ic_req_pc, 32'h100);

    // flush + response + pop in the same WAIT cycle
    serve(ADDI, 1'b0, 32'h104);
    check("pre_combo_head_pc", iq_out_pc, 32'h100);
    cyc();
    rob_flush = 1'b1; rob_flush_pc = 32'h200;
    ic_resp_valid = 1'b1; ic_resp_instr = JAL8; pred_if_jump = 1'b1; pred_predict_pc = 32'h999;
    iq_out_ready = 1'b1;
    cyc();
    rob_flush = 1'b0; ic_resp_valid = 1'b0; pred_if_jump = 1'b0; iq_out_ready = 1'b0;
    check("combo_iq_empty", iq_out_valid, 1'b0);
    check("combo_no_req", ic_req_valid, 1'b0);
    cyc();
    check("combo_req_valid", ic_req_valid, 1'b1);
    check("combo_req_pc", ic_req_pc, 32'h200);

    // freeze mid-WAIT with the response line toggling
    cyc();
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ic_resp_valid = (i % 2 == 0);
      ic_resp_instr = 32'hDEAD_BEEF; pred_if_jump = 1'b1; pred_predict_pc = 32'h300;
      cyc();
      check("freeze_no_req", ic_req_valid, 1'b0);
      check("freeze_no_push", iq_out_valid, 1'b0);
    end
    rdy = 1'b1; ic_resp_valid = 1'b0; pred_if_jump = 1'b0;
    cyc();
    check("resume_still_wait", ic_req_valid, 1'b0);
    serve(ADDI, 1'b0, 32'h204);
    check("resume_head_valid", iq_out_valid, 1'b1);
    check("resume_head_pc", iq_out_pc, 32'h200);
    check("resume_head_instr", iq_out_instr, ADDI);
    check("resume_req_pc", ic_req_pc, 32'h204);

    // pop the single entry, then pop an empty queue
    iq_out_ready = 1'b1;
    cyc(); cyc();
    iq_out_ready = 1'b0;
    check("empty_after_pops", iq_out_valid, 1'b0);
    serve(ADDI, 1'b0, 32'h208);
    check("after_empty_pop_valid", iq_out_valid, 1'b1);
    check("after_empty_pop_pc", iq_out_pc, 32'h204);
    check("after_empty_pop_req", ic_req_pc, 32'h208);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
